core_lsu: RTL and testbench

Parametrised load/store stage that replaces the pass-through memory stage between the EX/MEM and MEM/WB registers. It accepts one instruction at a time from EX/MEM over a valid/ready handshake and runs a request/response transaction on the data-memory port. It generates byte strobes and lane-aligned write data, and sign- or zero-extends load data. It holds the result for MEM/WB until it is accepted, so a slow data memory stalls the pipeline cleanly.

---
 rtl/core_lsu.sv | 163 ++++++++++++++++
 tb/tb_core_lsu.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// Load/store stage between EX/MEM and MEM/WB driving a request/response data-memory port.
// Define CORE_LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module core_lsu #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned AW   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              mem_rd_i,
   input  logic              mem_wr_i,
   input  logic [2:0]        funct3_i,
   input  logic [XLEN-1:0]   alu_i,
   input  logic [XLEN-1:0]   rs2_data_i,
   input  logic [4:0]        rsd_idx_i,
   input  logic [AW-1:0]     pc_i,
   output logic              dm_req_valid_o,
   input  logic              dm_req_ready_i,
   output logic              dm_req_we_o,
   output logic [AW-1:0]     dm_req_addr_o,
   output logic [XLEN-1:0]   dm_req_wdata_o,
   output logic [XLEN/8-1:0] dm_req_wstrb_o,
   input  logic              dm_rsp_valid_i,
   input  logic [XLEN-1:0]   dm_rsp_rdata_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   out_wb_data_o,
   output logic [4:0]        out_rsd_idx_o,
   output logic [AW-1:0]     out_pc_o,
   output logic              out_exc_o
);
   localparam int unsigned NB      = XLEN / 8;
   localparam int unsigned OW      = $clog2(NB);
   localparam logic [1:0]  MaxSize = 2'(OW);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;
   state_e state_q, state_d;

   logic [AW-1:0]   addr_q, pc_q;
   logic [OW-1:0]   off_q;
   logic [1:0]      size_q;
   logic            uns_q, store_q;
   logic [XLEN-1:0] wdata_q, wb_data_q;
   logic [NB-1:0]   wstrb_q;
   logic [4:0]      rsd_q;

   logic            accept, mem_op, trap, too_big, sign_bit;
   logic [1:0]      eff_size;
   logic [OW-1:0]   size_mask, off_raw, off;
   logic [AW-1:0]   addr_full;
   logic [XLEN-1:0] rep, wdata, load_sh, load_val;
   logic [NB-1:0]   strb_base, wstrb;

   assign accept = in_valid_i & in_ready_o;
   assign mem_op = mem_rd_i | mem_wr_i;

   // Access formatting evaluated on the accept cycle; oversized accesses clamp to the bus width.
   always_comb begin
      too_big   = 32'(funct3_i[1:0]) > OW;
      eff_size  = too_big ? MaxSize : funct3_i[1:0];
      size_mask = OW'((1 << eff_size) - 1);
      off_raw   = alu_i[OW-1:0];
      off       = off_raw & ~size_mask;
      addr_full = AW'(alu_i);
      rep       = '0;
      strb_base = '0;
      for (int i = 0; i < NB; i++) begin
         rep[i*8 +: 8] = rs2_data_i[(i % (1 << eff_size))*8 +: 8];
         strb_base[i]  = (i < (1 << eff_size));
      end
      wdata = rep << {off, 3'b000};
      wstrb = strb_base << off;
   end

   always_comb begin
      load_sh  = dm_rsp_rdata_i >> {off_q, 3'b000};
      sign_bit = ~uns_q & load_sh[(8 << size_q) - 1];
      load_val = '0;
      for (int i = 0; i < NB; i++) begin
         load_val[i*8 +: 8] = (i < (1 << size_q)) ? load_sh[i*8 +: 8] : {8{sign_bit}};
      end
   end

`ifdef CORE_LSU_MISALIGN_TRAP_EN
   logic exc_q;

   assign trap = mem_op & (too_big | (|(off_raw & size_mask)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exc_q <= 1'b0;
      end else if (accept) begin
         exc_q <= trap;
      end
   end

   assign out_exc_o = exc_q;
`else
   assign trap      = 1'b0;
   assign out_exc_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = (mem_op & ~trap) ? StReq : StHold;
         StReq:   if (dm_req_ready_i) state_d = store_q ? StHold : StWait;
         StWait:  if (dm_rsp_valid_i) state_d = StHold;
         StHold:  if (out_ready_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         off_q     <= '0;
         size_q    <= '0;
         uns_q     <= 1'b0;
         store_q   <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         pc_q      <= '0;
         rsd_q     <= '0;
         wb_data_q <= '0;
      end else if (accept) begin
         addr_q    <= {addr_full[AW-1:OW], {OW{1'b0}}};
         off_q     <= off;
         size_q    <= eff_size;
         uns_q     <= funct3_i[2];
         store_q   <= mem_wr_i;
         wdata_q   <= wdata;
         wstrb_q   <= wstrb;
         pc_q      <= pc_i;
         rsd_q     <= rsd_idx_i;
         wb_data_q <= alu_i;
      end else if ((state_q == StWait) && dm_rsp_valid_i) begin
         wb_data_q <= load_val;
      end
   end

   // Gated by rst_n so the stage reports not-ready while held in reset.
   assign in_ready_o     = rst_n & (state_q == StIdle);
   assign dm_req_valid_o = (state_q == StReq);
   assign dm_req_we_o    = store_q;
   assign dm_req_addr_o  = addr_q;
   assign dm_req_wdata_o = wdata_q;
   assign dm_req_wstrb_o = wstrb_q;
   assign out_valid_o    = (state_q == StHold);
   assign out_wb_data_o  = wb_data_q;
   assign out_rsd_idx_o  = rsd_q;
   assign out_pc_o       = pc_q;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu (XLEN=64, AW=64): directed cases plus randomized transactions
// checked against an arithmetic reference model.
module tb_core_lsu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid, in_ready, mem_rd, mem_wr;
   logic [2:0]  funct3;
   logic [63:0] alu, rs2, pc;
   logic [4:0]  rsd;
   logic        req_valid, req_ready, req_we;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wstrb;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        out_valid, out_ready, out_exc;
   logic [63:0] out_wb, out_pc;
   logic [4:0]  out_rsd;

   int n_vec = 0;
   int n_err = 0;

   core_lsu #(.XLEN(64), .AW(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid_i     (in_valid),
      .in_ready_o     (in_ready),
      .mem_rd_i       (mem_rd),
      .mem_wr_i       (mem_wr),
      .funct3_i       (funct3),
      .alu_i          (alu),
      .rs2_data_i     (rs2),
      .rsd_idx_i      (rsd),
      .pc_i           (pc),
      .dm_req_valid_o (req_valid),
      .dm_req_ready_i (req_ready),
      .dm_req_we_o    (req_we),
      .dm_req_addr_o  (req_addr),
      .dm_req_wdata_o (req_wdata),
      .dm_req_wstrb_o (req_wstrb),
      .dm_rsp_valid_i (rsp_valid),
      .dm_rsp_rdata_i (rsp_rdata),
      .out_valid_o    (out_valid),
      .out_ready_i    (out_ready),
      .out_wb_data_o  (out_wb),
      .out_rsd_idx_o  (out_rsd),
      .out_pc_o       (out_pc),
      .out_exc_o      (out_exc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic scramble_inputs();
      mem_rd = 1'($urandom);
      mem_wr = 1'($urandom);
      funct3 = 3'($urandom);
      alu    = {$urandom, $urandom};
      rs2    = {$urandom, $urandom};
      rsd    = 5'($urandom);
      pc     = {$urandom, $urandom};
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
      check({tag, "_req_we"}, 64'(req_we), 64'd0);
      check({tag, "_req_addr"}, req_addr, 64'd0);
      check({tag, "_req_wdata"}, req_wdata, 64'd0);
      check({tag, "_req_wstrb"}, 64'(req_wstrb), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_wb"}, out_wb, 64'd0);
      check({tag, "_out_rsd"}, 64'(out_rsd), 64'd0);
      check({tag, "_out_pc"}, out_pc, 64'd0);
      check({tag, "_out_exc"}, 64'(out_exc), 64'd0);
   endtask

   // One complete transaction; expectations come from byte-lane arithmetic on the request.
   task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] d, input logic [4:0] r,
                          input logic [63:0] p, input logic [63:0] rdata, input int rwait,
                          input int dwait, input int owait, input bit use_ovr,
                          input logic [63:0] ovr_wb);
      int          n, off, sb, guard;
      logic        is_mem, st, trap;
      logic [63:0] mask, mult, e_addr, e_wdata, e_wb, v;
      logic [7:0]  e_strb;
      n      = 1 << f3[1:0];
      is_mem = rd | wr;
      st     = wr;
      off    = (int'(a % 64'd8) / n) * n;
      trap   = 1'b0;
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      trap   = is_mem && ((a % 64'(n)) != 64'd0);
`endif
      e_addr = a - (a % 64'd8);
      sb     = ((1 << n) - 1) << off;
      e_strb = sb[7:0];
      mask   = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
      case (n)
         1:       mult = 64'h0101_0101_0101_0101;
         2:       mult = 64'h0001_0001_0001_0001;
         4:       mult = 64'h0000_0001_0000_0001;
         default: mult = 64'd1;
      endcase
      e_wdata = ((d & mask) * mult) << (8 * off);
      v = (rdata >> (8 * off)) & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
      e_wb = (is_mem && !st && !trap) ? v : a;
      if (use_ovr) e_wb = ovr_wb;

      guard = 0;
      while (!in_ready && guard < 10) begin
         tick();
         guard++;
      end
      check("idle_ready", 64'(in_ready), 64'd1);

      in_valid = 1'b1;
      mem_rd = rd; mem_wr = wr; funct3 = f3; alu = a; rs2 = d; rsd = r; pc = p;
      tick();
      in_valid = 1'b0;
      scramble_inputs();

      if (is_mem && !trap) begin
         for (int k = 0; k <= rwait; k++) begin
            req_ready = (k == rwait);
            rsp_valid = 1'($urandom);
            rsp_rdata = {$urandom, $urandom};
            check("req_valid", 64'(req_valid), 64'd1);
            check("req_we", 64'(req_we), 64'(st));
            check("req_addr", req_addr, e_addr);
            if (st) begin
               check("req_wdata", req_wdata, e_wdata);
               check("req_wstrb", 64'(req_wstrb), 64'(e_strb));
            end
            check("req_in_ready", 64'(in_ready), 64'd0);
            check("req_out_valid", 64'(out_valid), 64'd0);
            tick();
         end
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         if (!st) begin
            for (int k = 0; k < dwait; k++) begin
               check("wait_out_valid", 64'(out_valid), 64'd0);
               check("wait_req_valid", 64'(req_valid), 64'd0);
               check("wait_in_ready", 64'(in_ready), 64'd0);
               tick();
            end
            rsp_valid = 1'b1;
            rsp_rdata = rdata;
            tick();
            rsp_valid = 1'b0;
            rsp_rdata = {$urandom, $urandom};
         end
      end

      for (int k = 0; k <= owait; k++) begin
         out_ready = (k == owait);
         in_valid  = 1'($urandom);
         rsp_valid = 1'($urandom);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_wb", out_wb, e_wb);
         check("hold_rsd", 64'(out_rsd), 64'(r));
         check("hold_pc", out_pc, p);
         check("hold_exc", 64'(out_exc), 64'(trap));
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_req_valid", 64'(req_valid), 64'd0);
         tick();
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      rsp_valid = 1'b0;
      check("post_out_valid", 64'(out_valid), 64'd0);
      check("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   initial begin
      in_valid = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; out_ready = 1'b0;
      scramble_inputs();
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      tick();
      tick();
      #2 rst_n = 1'b1;
      #1 check("reset_release_ready", 64'(in_ready), 64'd1);
      tick();

      // Byte store at 0x1003, zero-wait memory.
      run_txn(1'b0, 1'b1, 3'd0, 64'h1003, 64'hAB, 5'd3, 64'h400, 64'd0, 0, 0, 0, 1'b0, 64'd0);
      // Signed and unsigned byte loads at 0x2005.
      run_txn(1'b1, 1'b0, 3'd0, 64'h2005, 64'd0, 5'd7, 64'h404, 64'h0000_8000_0000_0000,
              0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
      run_txn(1'b1, 1'b0, 3'd4, 64'h2005, 64'd0, 5'd8, 64'h408, 64'h0000_8000_0000_0000,
              0, 0, 0, 1'b1, 64'h80);
      // Slow response and slow consumer; then a stalled request.
      run_txn(1'b1, 1'b0, 3'd2, 64'h2104, 64'd0, 5'd9, 64'h40C, 64'h8765_4321_DEAD_BEEF,
              0, 5, 3, 1'b0, 64'd0);
      run_txn(1'b0, 1'b1, 3'd1, 64'h2206, 64'h1234, 5'd10, 64'h410, 64'd0, 4, 0, 0, 1'b0, 64'd0);
      // Misaligned half-word load at 0x3001.
`ifdef CORE_LSU_MISALIGN_TRAP_EN
      run_txn(1'b1, 1'b0, 3'd1, 64'h3001, 64'd0, 5'd11, 64'h414, 64'h0000_0000_0000_F00D,
              0, 0, 0, 1'b1, 64'h3001);
`else
      run_txn(1'b1, 1'b0, 3'd1, 64'h3001, 64'd0, 5'd11, 64'h414, 64'h0000_0000_0000_F00D,
              0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_F00D);
`endif
      // Pass-through and read+write (store) cases.
      run_txn(1'b0, 1'b0, 3'd3, 64'hCAFE_F00D_1234_5678, 64'd0, 5'd12, 64'h418, 64'd0,
              0, 0, 1, 1'b0, 64'd0);
      run_txn(1'b1, 1'b1, 3'd3, 64'h5000, 64'h0102_0304_0506_0708, 5'd13, 64'h41C, 64'd0,
              1, 0, 0, 1'b0, 64'd0);

      for (int t = 0; t < 60; t++) begin
         int kind;
         kind = int'($urandom % 4);
         run_txn(kind == 1 || kind == 3, kind >= 2, 3'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, 5'($urandom), {$urandom, $urandom},
                 {$urandom, $urandom}, int'($urandom % 4), int'($urandom % 4),
                 int'($urandom % 4), 1'b0, 64'd0);
      end

      // Reset while waiting for a load response; a late response must be ignored.
      in_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'd3; alu = 64'h6000;
      rsd = 5'd20; pc = 64'h500;
      tick();
      in_valid = 1'b0;
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      tick();
      check("mid_wait_valid", 64'(out_valid), 64'd0);
      rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      rsp_valid = 1'b1;
      rsp_rdata = 64'h1111_2222_3333_4444;
      tick();
      #2 rst_n = 1'b1;
      tick();
      tick();
      check("late_rsp_out_valid", 64'(out_valid), 64'd0);
      check("late_rsp_in_ready", 64'(in_ready), 64'd1);
      rsp_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: observed no completion, required finish before 500000");
      $fatal(1, "timeout");
   end
endmodule
